// File: rtl/vga_line_select_if.sv
// Bundle of the selector's data/control signals.
// The master side drives mode, selection, pulses and channel words.
// The slave side (the selector) returns the registered word, flags and index.
interface vga_line_select_if #(
    parameter int DATA_WIDTH   = 12,
    parameter int CHANNELS     = 15,
    parameter int SELECT_WIDTH = 4
);
    logic                           mode;
    logic [SELECT_WIDTH-1:0]        sel_in;
    logic                           line_strobe;
    logic                           frame_start;
    logic [CHANNELS*DATA_WIDTH-1:0] d_in;
    logic                           in_valid;
    logic [DATA_WIDTH-1:0]          o_q;
    logic                           o_valid;
    logic [SELECT_WIDTH-1:0]        o_sel;
    logic                           o_err;

    modport master (
        output mode, sel_in, line_strobe, frame_start, d_in, in_valid,
        input  o_q, o_valid, o_sel, o_err
    );

    modport slave (
        input  mode, sel_in, line_strobe, frame_start, d_in, in_valid,
        output o_q, o_valid, o_sel, o_err
    );
endinterface

// File: rtl/vga_line_select.sv
// Line/channel selector: picks one of CHANNELS packed words either by a
// manual index or by an auto line-scan counter, and registers the result.
// The index register is exported as o_sel; the output stage uses the index
// value from before its own update, giving one cycle of output latency.
module vga_line_select #(
    parameter int DATA_WIDTH   = 12,
    parameter int CHANNELS     = 15,
    parameter int SELECT_WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    vga_line_select_if.slave  bus
);

    // Highest legal index; the scan wraps to 0 from here (or from anything above).
    localparam logic [SELECT_WIDTH-1:0] LAST_SEL = SELECT_WIDTH'(CHANNELS - 1);

    logic [SELECT_WIDTH-1:0] cur_sel_q, cur_sel_d;
    logic [DATA_WIDTH-1:0]   o_q_q, o_q_d;
    logic                    o_valid_q, o_valid_d;
    logic                    o_err_q, o_err_d;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic                    sel_hit;

    // Next index: manual follows sel_in; auto restarts on frame_start, steps on line_strobe.
    always_comb begin
        cur_sel_d = cur_sel_q;
        if (!bus.mode) begin
            cur_sel_d = bus.sel_in;
        end else if (bus.frame_start) begin
            cur_sel_d = '0;
        end else if (bus.line_strobe) begin
            cur_sel_d = (cur_sel_q >= LAST_SEL) ? '0 : cur_sel_q + 1'b1;
        end
    end

    // Index decode of the current channel word; no hit means the index is out of range.
    always_comb begin
        sel_word = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_sel_q == SELECT_WIDTH'(k)) begin
                sel_word = bus.d_in[k*DATA_WIDTH +: DATA_WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    // Output stage next state: word and error only update on valid input, word holds otherwise.
    always_comb begin
        o_valid_d = bus.in_valid;
        o_err_d   = bus.in_valid & ~sel_hit;
        o_q_d     = o_q_q;
        if (bus.in_valid) begin
            o_q_d = sel_hit ? sel_word : '0;
        end
    end

    // State registers with synchronous reset clearing index and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_sel_q <= '0;
            o_q_q     <= '0;
            o_valid_q <= 1'b0;
            o_err_q   <= 1'b0;
        end else begin
            cur_sel_q <= cur_sel_d;
            o_q_q     <= o_q_d;
            o_valid_q <= o_valid_d;
            o_err_q   <= o_err_d;
        end
    end

    assign bus.o_sel   = cur_sel_q;
    assign bus.o_q     = o_q_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_err   = o_err_q;

endmodule

// File: tb/tb_vga_line_select.sv
// Scoreboard bench for vga_line_select: the driver pushes hand-computed
// expectations tagged with the cycle they must appear on; a monitor on the
// falling edge compares and retires them.
module tb_vga_line_select;
    localparam int DW = 12;
    localparam int CH = 15;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_line_select_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .SELECT_WIDTH(SW)) bus ();

    vga_line_select #(.DATA_WIDTH(DW), .CHANNELS(CH), .SELECT_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int              cyc;
        bit              is_sel;
        logic            v;
        logic [DW-1:0]   q;
        logic            e;
        logic [SW-1:0]   s;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int vals [CH] = '{14, 4, 23, 5, 6, 8, 12, 23, 23, 1, 2, 3, 22, 33, 44};
    int wrap_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    endtask

    // Monitor: retire every expectation due on this cycle, flag any that slipped past.
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].is_sel) begin
                    chk("o_sel", 32'(bus.o_sel), 32'(sb[i].s));
                end else begin
                    chk("o_valid", 32'(bus.o_valid), 32'(sb[i].v));
                    chk("o_q", 32'(bus.o_q), 32'(sb[i].q));
                    chk("o_err", 32'(bus.o_err), 32'(sb[i].e));
                end
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                $display("FAIL missed_check at cycle %0d: got none, expected entry for cycle %0d", cyc, sb[i].cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input int dly, input logic v, input int q, input logic e);
        exp_t x;
        x.cyc = cyc + dly; x.is_sel = 1'b0;
        x.v = v; x.q = DW'(q); x.e = e; x.s = '0;
        sb.push_back(x);
    endtask

    task automatic push_s(input int dly, input int s);
        exp_t x;
        x.cyc = cyc + dly; x.is_sel = 1'b1;
        x.v = 1'b0; x.q = '0; x.e = 1'b0; x.s = SW'(s);
        sb.push_back(x);
    endtask

    initial begin
        reset           = 1'b1;
        bus.mode        = 1'b0;
        bus.sel_in      = 4'd3;
        bus.line_strobe = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b1;
        bus.d_in        = '0;
        for (int k = 0; k < CH; k++) bus.d_in[k*DW +: DW] = DW'(vals[k]);

        // Reset must override valid input and manual selection.
        step(); step();
        push_d(1, 1'b0, 0, 1'b0); push_s(1, 0);
        step();
        reset = 1'b0;

        // Manual sweep over all channels.
        for (int k = 0; k < CH; k++) begin
            bus.sel_in = SW'(k);
            push_d(2, 1'b1, vals[k], 1'b0);
            step();
        end

        // Out of range, then back in range.
        bus.sel_in = 4'd15; push_d(2, 1'b1, 0, 1'b1); step();
        bus.sel_in = 4'd3;  push_d(2, 1'b1, 5, 1'b0); step();
        step();

        // Valid gating while sel_in moves, including an out-of-range index.
        bus.in_valid = 1'b0;
        bus.sel_in = 4'd1;  push_d(1, 1'b0, 5, 1'b0); step();
        bus.sel_in = 4'd15; push_d(1, 1'b0, 5, 1'b0); step();
        bus.sel_in = 4'd15; push_d(1, 1'b0, 5, 1'b0); step();

        // Manual -> auto keeps the manual index and scans on from it.
        bus.sel_in = 4'd5; step();
        bus.mode = 1'b1; bus.sel_in = 4'd12; push_s(1, 5); step();
        bus.line_strobe = 1'b1; push_s(1, 6); step();

        // Frame start then 16 strobes through the wrap.
        bus.line_strobe = 1'b0; bus.frame_start = 1'b1; push_s(1, 0); step();
        bus.frame_start = 1'b0; bus.line_strobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_s(1, wrap_exp[i]);
            step();
        end

        // Advance to 7, then both pulses together.
        for (int i = 0; i < 6; i++) begin
            push_s(1, 2 + i);
            step();
        end
        bus.frame_start = 1'b1; push_s(1, 0); step();
        bus.frame_start = 1'b0;

        // Scan to 9 with valid data, hold, then reset mid-scan.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_s(1, i + 1);
            step();
        end
        bus.line_strobe = 1'b0;
        push_s(1, 9); push_d(1, 1'b1, vals[9], 1'b0); step();
        reset = 1'b1; bus.line_strobe = 1'b1;
        push_d(1, 1'b0, 0, 1'b0); push_s(1, 0); step();
        reset = 1'b0; bus.in_valid = 1'b0;
        push_s(1, 1); push_d(1, 1'b0, 0, 1'b0); step();

        // Auto -> manual takes sel_in on the same edge.
        bus.line_strobe = 1'b0; bus.mode = 1'b0; bus.sel_in = 4'd4;
        push_s(1, 4); step();
        step(); step();

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
